// File: rtl/cpu_pkg.sv
// Shared constants and types for the basic 10-bit CPU.
//   CPU_ADDR_W     : PC / stack data / vector width
//   CPU_N_IRQ      : default number of interrupt lines (bit 0 = highest priority)
//   CPU_VEC_BASE   : vector address of interrupt line 0
//   CPU_VEC_STRIDE : words between consecutive interrupt vectors
//   irq_id_t       : index of one interrupt line at the default line count
package cpu_pkg;

  localparam int CPU_ADDR_W = 10;
  localparam int CPU_N_IRQ = 4;
  localparam logic [CPU_ADDR_W-1:0] CPU_VEC_BASE = 10'h3C0;
  localparam int CPU_VEC_STRIDE = 4;

  typedef logic [$clog2(CPU_N_IRQ)-1:0] irq_id_t;

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-set-bit priority encoder.
//   req   : request vector, bit 0 has the highest priority
//   valid : at least one bit of req is set
//   id    : index of the lowest set bit of req (0 when valid=0)
module intr_prio_enc #(
  parameter int N = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  output logic           valid,
  output logic [IDW-1:0] id
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Prioritised, nestable interrupt controller sitting in front of the
// return-address stack and the PC mux.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   irq         : interrupt requests, rising-edge sensitive
//   mask_we     : load mask register from mask_din (1 = line enabled)
//   reti        : CPU return-from-interrupt this cycle (stack pop)
//   stack_op    : CPU call/ret uses the stack this cycle
//   intr_take   : interrupt accepted; stack push + PC mux select
//   vec_addr    : vector of the accepted line while intr_take=1, else 0
//   s_intr      : current stack pop is an interrupt return
//   pending     : latched requests not yet accepted
//   in_service  : interrupts currently being serviced
//   mask        : current mask register
//
// Stack handshake: the stack has a single port and no ready signal. A push
// (intr_take) is only raised in a cycle where the CPU is not using the stack
// (stack_op=0, reti=0), so it is always accepted in the cycle it is shown.
// A blocked request stays pending and is offered again every cycle.
module intr_ctrl #(
  parameter int N_IRQ = cpu_pkg::CPU_N_IRQ,
  parameter int ADDR_W = cpu_pkg::CPU_ADDR_W,
  parameter logic [ADDR_W-1:0] VEC_BASE = cpu_pkg::CPU_VEC_BASE,
  parameter int VEC_STRIDE = cpu_pkg::CPU_VEC_STRIDE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IRQ-1:0]  irq,
  input  logic              mask_we,
  input  logic [N_IRQ-1:0]  mask_din,
  input  logic              reti,
  input  logic              stack_op,
  output logic              intr_take,
  output logic [ADDR_W-1:0] vec_addr,
  output logic              s_intr,
  output logic [N_IRQ-1:0]  pending,
  output logic [N_IRQ-1:0]  in_service,
  output logic [N_IRQ-1:0]  mask
);

  localparam int IDW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic [N_IRQ-1:0]  irq_q;
  logic [N_IRQ-1:0]  rise;
  logic [N_IRQ-1:0]  cand;
  logic              cand_v;
  logic [IDW-1:0]    cand_id;
  logic              hp_v;
  logic [IDW-1:0]    hp_id;
  logic              eligible;
  logic [ADDR_W-1:0] vec_calc;
  logic [N_IRQ-1:0]  take_oh;
  logic [N_IRQ-1:0]  ret_oh;

  assign rise = irq & ~irq_q;
  assign cand = pending & mask;

  intr_prio_enc #(.N(N_IRQ), .IDW(IDW)) u_cand_enc (
    .req   (cand),
    .valid (cand_v),
    .id    (cand_id)
  );

  intr_prio_enc #(.N(N_IRQ), .IDW(IDW)) u_hp_enc (
    .req   (in_service),
    .valid (hp_v),
    .id    (hp_id)
  );

  // Only a strictly higher priority (lower index) than the innermost
  // in-service level may preempt.
  assign eligible = cand_v && (!hp_v || (cand_id < hp_id));

  assign intr_take = eligible & ~stack_op & ~reti & ~reset;
  assign s_intr    = reti & hp_v & ~reset;

  // Vector arithmetic wraps modulo 2^ADDR_W.
  assign vec_calc = VEC_BASE + ADDR_W'(cand_id) * ADDR_W'(VEC_STRIDE);
  assign vec_addr = intr_take ? vec_calc : '0;

  // take and return are mutually exclusive (reti blocks a take).
  assign take_oh = intr_take ? (N_IRQ'(1) << cand_id) : '0;
  assign ret_oh  = s_intr ? (N_IRQ'(1) << hp_id) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q      <= '0;
      pending    <= '0;
      in_service <= '0;
      mask       <= '0;
    end else begin
      irq_q <= irq;
      // A fresh edge in the take cycle wins over the clear.
      pending    <= (pending & ~take_oh) | rise;
      in_service <= (in_service | take_oh) & ~ret_oh;
      if (mask_we) begin
        mask <= mask_din;
      end
    end
  end

endmodule
